instruction_fetch_unit: RTL and testbench

//  Fetch stage and writer side of the IF/ID boundary. Holds the PC, issues req/ack reads to instruction memory,
//  and presents fetched words plus their PC to the IF/ID register. Obeys the same ifid_write stall and
//  if_flush redirect that the IF/ID register consumes. A two-deep output buffer (out + skid) absorbs stalls.

---
 rtl/ifu_pkg.sv | 13 +
 rtl/ifu_skid_buffer.sv | 41 ++++
 rtl/instruction_fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared state encoding and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        StFetch   = 2'd0,
        StHold    = 2'd1,
        StDiscard = 2'd2
    } ifu_state_e;

    localparam logic [31:0] NOP_INSTR = 32'b0;
    localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/ifu_skid_buffer.sv
// One-entry {instr, pc} holding register that sits behind the IF/ID output register.
module ifu_skid_buffer
    import ifu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_unload,
    input  logic              i_clear,
    input  logic [31:0]       i_instr,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_valid,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_pc
);

    logic              r_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
        end else if (i_clear || i_unload) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, req/ack instruction-memory reads, and the IF/ID write side with a skid entry.
// Optional feature: define IFU_MISALIGN_TRAP_EN to trap misaligned redirects via fetch_fault.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              ifid_write,
    input  logic              if_flush,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid,
    output logic              fetch_fault
);

    ifu_state_e        r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic [ADDR_W-1:0] r_disc_addr, w_disc_addr_next;
    logic              r_out_valid, w_out_valid_next;
    logic [31:0]       r_out_instr, w_out_instr_next;
    logic [ADDR_W-1:0] r_out_pc, w_out_pc_next;

    logic              w_fault;
    logic              w_misalign;
    logic [ADDR_W-1:0] w_redirect;
    logic              w_xfer;
    logic              w_fetching;

    logic              w_skid_load, w_skid_unload, w_skid_clear;
    logic              w_skid_valid;
    logic [31:0]       w_skid_instr;
    logic [ADDR_W-1:0] w_skid_pc;

`ifdef IFU_MISALIGN_TRAP_EN
    logic r_fault;

    assign w_misalign = |redirect_pc[1:0];
    assign w_redirect = redirect_pc;
    assign w_fault    = r_fault;

    // Only a flush can enter or leave the fault; an aligned redirect clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (if_flush) begin
            r_fault <= w_misalign;
        end
    end
`else
    assign w_misalign = 1'b0;
    assign w_redirect = redirect_pc & ~ADDR_W'(3);
    assign w_fault    = 1'b0;
`endif

    assign w_fetching = (r_state == StFetch) && !w_fault;
    assign imem_req   = !rst && (w_fetching || (r_state == StDiscard));
    assign imem_addr  = (r_state == StDiscard) ? r_disc_addr : r_pc;
    assign w_xfer     = r_out_valid && ifid_write && !if_flush;

    assign instr_valid = r_out_valid;
    assign instr_out   = r_out_valid ? r_out_instr : NOP_INSTR;
    assign pc_out      = r_out_pc;
    assign fetch_fault = w_fault;

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_disc_addr_next = r_disc_addr;
        w_out_valid_next = r_out_valid && !w_xfer;
        w_out_instr_next = r_out_instr;
        w_out_pc_next    = r_out_pc;
        w_skid_load      = 1'b0;
        w_skid_unload    = 1'b0;
        w_skid_clear     = 1'b0;

        if (if_flush) begin
            w_pc_next        = w_redirect;
            w_out_valid_next = 1'b0;
            w_out_instr_next = NOP_INSTR;
            w_skid_clear     = 1'b1;
            w_disc_addr_next = imem_addr;
            // A request left without its ack must still finish on the bus; its data is dropped.
            if (imem_req && !imem_ack && !w_misalign) begin
                w_state_next = StDiscard;
            end else begin
                w_state_next = StFetch;
            end
        end else begin
            unique case (r_state)
                StFetch: begin
                    if (w_fetching && imem_ack) begin
                        w_pc_next = r_pc + ADDR_W'(PC_STEP);
                        if (!r_out_valid || w_xfer) begin
                            w_out_valid_next = 1'b1;
                            w_out_instr_next = imem_rdata;
                            w_out_pc_next    = r_pc;
                        end else begin
                            w_skid_load  = 1'b1;
                            w_state_next = StHold;
                        end
                    end
                end
                StHold: begin
                    if (w_xfer) begin
                        w_out_valid_next = w_skid_valid;
                        w_out_instr_next = w_skid_instr;
                        w_out_pc_next    = w_skid_pc;
                        w_skid_unload    = 1'b1;
                        w_state_next     = StFetch;
                    end
                end
                StDiscard: begin
                    if (imem_ack) begin
                        w_state_next = StFetch;
                    end
                end
                default: w_state_next = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StFetch;
            r_pc        <= RESET_PC;
            r_disc_addr <= '0;
            r_out_valid <= 1'b0;
            r_out_instr <= NOP_INSTR;
            r_out_pc    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_disc_addr <= w_disc_addr_next;
            r_out_valid <= w_out_valid_next;
            r_out_instr <= w_out_instr_next;
            r_out_pc    <= w_out_pc_next;
        end
    end

    ifu_skid_buffer #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_clear  (w_skid_clear),
        .i_instr  (imem_rdata),
        .i_pc     (r_pc),
        .o_valid  (w_skid_valid),
        .o_instr  (w_skid_instr),
        .o_pc     (w_skid_pc)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit with a latency-programmable memory model and a pc scoreboard.
// The misaligned-redirect case follows IFU_MISALIGN_TRAP_EN when it is defined.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ifid_write;
    logic        if_flush;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        fetch_fault;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat   = 0;
    int          mem_cnt = 0;
    bit          chk_en   = 1'b0;
    bit          chk_lead = 1'b0;
    logic [31:0] sb[$];
    int          xfer_t[$];

    typedef struct packed {
        int lat;
        int nwords;
        int gap;
    } vec_t;
    vec_t vecs[3];

    instruction_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ifid_write  (ifid_write),
        .if_flush    (if_flush),
        .redirect_pc (redirect_pc),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .instr_valid (instr_valid),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory: ack once the request has been held for lat cycles.
    assign imem_ack   = imem_req && (mem_cnt >= lat);
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst || !imem_req || imem_ack) mem_cnt <= 0;
        else mem_cnt <= mem_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Consumer: every IF/ID transfer pops the scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (chk_en && instr_valid && ifid_write && !if_flush) begin
                xfer_t.push_back(cyc);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_xfer actual_pc=%h required=none", pc_out);
                end else begin
                    e = sb.pop_front();
                    chk("xfer_pc", pc_out, e);
                    chk("xfer_instr", instr_out, mem_word(e));
                    if (chk_lead) chk("addr_lead", imem_addr, e + 32'd4);
                end
            end
        end
    end

    task automatic do_reset(input int l, input logic w);
        chk_en   = 1'b0;
        chk_lead = 1'b0;
        sb.delete();
        xfer_t.delete();
        lat         = l;
        rst         = 1'b1;
        if_flush    = 1'b0;
        redirect_pc = 32'h0;
        ifid_write  = w;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("req_after_rst", {31'b0, imem_req}, 32'h1);
        chk("addr_after_rst", imem_addr, 32'h0);
        chk_en = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout left=%0d required=0", name, sb.size());
        end
    endtask

    task automatic pulse_flush(input logic [31:0] target);
        @(posedge clk);
        #1;
        if_flush    = 1'b1;
        redirect_pc = target;
        @(posedge clk);
        #1;
        if_flush = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        vecs[0] = '{lat: 0, nwords: 8, gap: 1};
        vecs[1] = '{lat: 1, nwords: 5, gap: 2};
        vecs[2] = '{lat: 3, nwords: 4, gap: 4};

        // Streaming throughput versus memory latency.
        for (int v = 0; v < 3; v++) begin
            do_reset(vecs[v].lat, 1'b1);
            chk_lead = (vecs[v].lat == 0);
            for (int i = 0; i < vecs[v].nwords; i++) sb.push_back(32'(i * 4));
            drain("stream", 100);
            chk_en = 1'b0;
            chk("stream_count", 32'(xfer_t.size()), 32'(vecs[v].nwords));
            for (int i = 1; i < xfer_t.size(); i++)
                chk("stream_gap", 32'(xfer_t[i] - xfer_t[i-1]), 32'(vecs[v].gap));
        end

        // Stall: out and skid fill, request stops, then two back-to-back transfers.
        do_reset(0, 1'b0);
        for (int i = 0; i < 6; i++) sb.push_back(32'(i * 4));
        repeat (4) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_req", {31'b0, imem_req}, 32'h0);
            chk("hold_valid", {31'b0, instr_valid}, 32'h1);
            chk("hold_pc_out", pc_out, 32'h0);
            chk("hold_instr", instr_out, mem_word(32'h0));
        end
        @(posedge clk);
        #1 ifid_write = 1'b1;
        drain("stall", 50);
        chk_en = 1'b0;
        chk("stall_count", 32'(xfer_t.size()), 32'd6);
        if (xfer_t.size() >= 2) chk("stall_b2b", 32'(xfer_t[1] - xfer_t[0]), 32'd1);

        // Flush while a request is pending; its late ack must be dropped.
        do_reset(3, 1'b1);
        sb.push_back(32'h0);
        drain("pre_flush", 50);
        n = 0;
        while (!(imem_req && imem_addr == 32'h4 && mem_cnt == 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        pulse_flush(32'h100);
        chk("discard_addr", imem_addr, 32'h4);
        chk("discard_req", {31'b0, imem_req}, 32'h1);
        chk("discard_valid", {31'b0, instr_valid}, 32'h0);
        sb.push_back(32'h100);
        sb.push_back(32'h104);
        n = 0;
        while (imem_addr == 32'h4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("redirect_addr", imem_addr, 32'h100);
        drain("post_flush", 50);
        chk_en = 1'b0;

        // Flush coinciding with an ack.
        do_reset(0, 1'b1);
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        sb.push_back(32'h8);
        drain("pre_ackflush", 50);
        pulse_flush(32'h40);
        chk("ackflush_valid", {31'b0, instr_valid}, 32'h0);
        chk("ackflush_instr", instr_out, 32'h0);
        chk("ackflush_addr", imem_addr, 32'h40);
        sb.push_back(32'h40);
        sb.push_back(32'h44);
        drain("post_ackflush", 50);
        chk_en = 1'b0;

        // Misaligned redirect.
        do_reset(0, 1'b1);
        sb.push_back(32'h0);
        drain("pre_misalign", 50);
        pulse_flush(32'h102);
`ifdef IFU_MISALIGN_TRAP_EN
        chk("fault_set", {31'b0, fetch_fault}, 32'h1);
        chk("fault_valid", {31'b0, instr_valid}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("fault_no_req", {31'b0, imem_req}, 32'h0);
            @(negedge clk);
        end
        pulse_flush(32'h200);
        chk("fault_clear", {31'b0, fetch_fault}, 32'h0);
        chk("fault_resume_req", {31'b0, imem_req}, 32'h1);
        chk("fault_resume_addr", imem_addr, 32'h200);
        sb.push_back(32'h200);
        sb.push_back(32'h204);
`else
        chk("nofault", {31'b0, fetch_fault}, 32'h0);
        chk("masked_addr", imem_addr, 32'h100);
        sb.push_back(32'h100);
        sb.push_back(32'h104);
`endif
        drain("post_misalign", 50);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
